// File: rtl/ddr_req_arbiter.sv
// Round-robin DDR request arbiter with same-row streaking across NUM_CH FWFT queues.
// Optional DDR_ARB_STATS_EN adds saturating issue/hit counters.
module ddr_req_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int ROW_LSB    = 13,
  parameter int MAX_STREAK = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_empty,
  input  logic [NUM_CH*ADDR_W-1:0] ch_adrs,
  output logic [NUM_CH-1:0]        ch_pop,
  input  logic                     ready,
  output logic                     cmd_valid,
  output logic [ADDR_W-1:0]        cmd_adrs,
  output logic [CH_W-1:0]          cmd_ch,
  output logic                     cmd_hit,
`ifdef DDR_ARB_STATS_EN
  output logic [15:0]              issue_cnt,
  output logic [15:0]              hit_cnt,
`endif
  output logic                     busy
);

  // Handshake: a command transfers on a rising edge with cmd_valid && ready; while
  // cmd_valid && !ready the command outputs hold and no queue is popped.
  localparam int ROW_W = ADDR_W - ROW_LSB;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic [CH_W-1:0]   last_grant;
  logic [3:0]        streak;
  logic [ROW_W-1:0]  last_row;
  logic              last_row_valid;

  logic [ADDR_W-1:0] head [NUM_CH];
  logic              rr_found;
  logic [CH_W-1:0]   rr_ch;
  logic              xfer;
  logic              same_ok;
  logic              sel_same;
  logic              sel_rr;
  logic              pop_any;
  logic [CH_W-1:0]   pop_ch;
  logic [ADDR_W-1:0] new_adrs;
  logic              new_hit;

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ROW_LSB];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) head[i] = ch_adrs[i*ADDR_W +: ADDR_W];
  end

  // First non-empty channel after the last grant, wrapping at NUM_CH.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!rr_found && !ch_empty[(int'(last_grant) + k) % NUM_CH]) begin
        rr_found = 1'b1;
        rr_ch    = CH_W'((int'(last_grant) + k) % NUM_CH);
      end
    end
  end

  assign xfer    = cmd_valid && ready;
  assign same_ok = !ch_empty[cmd_ch] && (row_of(head[cmd_ch]) == row_of(cmd_adrs)) &&
                   (streak < 4'(MAX_STREAK));

  always_comb begin
    sel_same = 1'b0;
    sel_rr   = 1'b0;
    if (rst) begin
      if (state == IDLE) begin
        sel_rr = rr_found;
      end else if (xfer) begin
        if (same_ok) sel_same = 1'b1;
        else         sel_rr   = rr_found;
      end
    end
  end

  assign pop_any  = sel_same || sel_rr;
  assign pop_ch   = sel_same ? cmd_ch : rr_ch;
  assign new_adrs = head[pop_ch];

  always_comb begin
    if (sel_same)           new_hit = 1'b1;
    else if (state == IDLE) new_hit = last_row_valid && (row_of(new_adrs) == last_row);
    else                    new_hit = (row_of(new_adrs) == row_of(cmd_adrs));
  end

  always_comb begin
    ch_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pop_any && (pop_ch == CH_W'(i))) ch_pop[i] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cmd_valid      <= 1'b0;
      cmd_adrs       <= '0;
      cmd_ch         <= '0;
      cmd_hit        <= 1'b0;
      last_grant     <= CH_W'(NUM_CH - 1);
      streak         <= '0;
      last_row       <= '0;
      last_row_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_rr) begin
            cmd_valid  <= 1'b1;
            cmd_adrs   <= new_adrs;
            cmd_ch     <= rr_ch;
            cmd_hit    <= new_hit;
            last_grant <= rr_ch;
            streak     <= 4'd1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer) begin
            last_row       <= row_of(cmd_adrs);
            last_row_valid <= 1'b1;
            if (pop_any) begin
              cmd_adrs <= new_adrs;
              cmd_ch   <= pop_ch;
              cmd_hit  <= new_hit;
              if (sel_same) begin
                streak <= streak + 4'd1;
              end else begin
                streak     <= 4'd1;
                last_grant <= rr_ch;
              end
            end else begin
              // Going idle forgets the row so the next burst starts as a miss.
              cmd_valid      <= 1'b0;
              cmd_hit        <= 1'b0;
              last_row_valid <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_cnt <= '0;
      hit_cnt   <= '0;
    end else if (xfer) begin
      if (issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
      if (cmd_hit && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Bench for ddr_req_arbiter: directed scenarios plus random traffic against a
// queue-based reference model; stats checks compile in with DDR_ARB_STATS_EN.
module tb_ddr_req_arbiter;

  localparam int AW  = 32;
  localparam int NCH = 3;
  localparam int RL  = 13;
  localparam int MS  = 4;
  localparam int CW  = 2;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_empty;
  logic [NCH*AW-1:0] ch_adrs;
  logic [NCH-1:0]    ch_pop;
  logic              ready;
  logic              cmd_valid;
  logic [AW-1:0]     cmd_adrs;
  logic [CW-1:0]     cmd_ch;
  logic              cmd_hit;
  logic              busy;
`ifdef DDR_ARB_STATS_EN
  logic [15:0]       issue_cnt;
  logic [15:0]       hit_cnt;
`endif

  ddr_req_arbiter #(.ADDR_W(AW), .NUM_CH(NCH), .ROW_LSB(RL), .MAX_STREAK(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_empty  (ch_empty),
    .ch_adrs   (ch_adrs),
    .ch_pop    (ch_pop),
    .ready     (ready),
    .cmd_valid (cmd_valid),
    .cmd_adrs  (cmd_adrs),
    .cmd_ch    (cmd_ch),
    .cmd_hit   (cmd_hit),
`ifdef DDR_ARB_STATS_EN
    .issue_cnt (issue_cnt),
    .hit_cnt   (hit_cnt),
`endif
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [AW-1:0]      q [NCH][$];
  logic [AW+CW:0]     exp_q [$];
  int                 n_checks = 0;
  int                 n_errors = 0;

  logic               m_valid;
  logic [AW-1:0]      m_adrs;
  int                 m_ch;
  logic               m_hit;
  int                 m_streak;
  int                 m_last_grant;
  logic [AW-RL-1:0]   m_last_row;
  logic               m_lrv;
  int                 m_issue;
  int                 m_hits;

  function automatic logic [AW-RL-1:0] row_of(input logic [AW-1:0] a);
    return a[AW-1:RL];
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= NCH; k++) begin
      if (q[(m_last_grant + k) % NCH].size() > 0) return (m_last_grant + k) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_adrs = '0; m_ch = 0; m_hit = 1'b0; m_streak = 0;
    m_last_grant = NCH - 1; m_last_row = '0; m_lrv = 1'b0;
    m_issue = 0; m_hits = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int c = 0; c < NCH; c++) begin
      ch_empty[c] = (q[c].size() == 0);
      ch_adrs[c*AW +: AW] = (q[c].size() > 0) ? q[c][0] : AW'($urandom());
    end
  endtask

  task automatic expect_cmd(input int ch, input logic hit, input logic [AW-1:0] a);
    exp_q.push_back({hit, CW'(ch), a});
  endtask

  // One clock cycle: drive, check DUT against model, advance model, cross the edge.
  task automatic step(input logic r, input logic rs);
    logic [NCH-1:0] exp_pop;
    logic [AW+CW:0] e;
    int             g;
    logic [AW-RL-1:0] lr;
    rst = rs;
    ready = r;
    drive_inputs();
    #1;
    chk("busy", 64'(busy), 64'(m_valid));
    chk("cmd_valid", 64'(cmd_valid), 64'(m_valid));
    if (m_valid) begin
      chk("cmd_adrs", 64'(cmd_adrs), 64'(m_adrs));
      chk("cmd_ch", 64'(cmd_ch), 64'(m_ch));
      chk("cmd_hit", 64'(cmd_hit), 64'(m_hit));
    end
`ifdef DDR_ARB_STATS_EN
    chk("issue_cnt", 64'(issue_cnt), 64'(m_issue));
    chk("hit_cnt", 64'(hit_cnt), 64'(m_hits));
`endif
    exp_pop = '0;
    if (!rs) begin
      model_reset();
    end else if (!m_valid) begin
      g = rr_pick();
      if (g >= 0) begin
        exp_pop[g] = 1'b1;
        m_adrs = q[g].pop_front();
        m_hit = m_lrv && (row_of(m_adrs) == m_last_row);
        m_ch = g; m_last_grant = g; m_streak = 1; m_valid = 1'b1;
      end
    end else if (r) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("xfer_adrs", 64'(cmd_adrs), 64'(e[AW-1:0]));
        chk("xfer_ch", 64'(cmd_ch), 64'(e[AW+CW-1:AW]));
        chk("xfer_hit", 64'(cmd_hit), 64'(e[AW+CW]));
      end
      if (m_issue < 16'hFFFF) m_issue++;
      if (m_hit && m_hits < 16'hFFFF) m_hits++;
      lr = row_of(m_adrs);
      m_last_row = lr;
      m_lrv = 1'b1;
      if (q[m_ch].size() > 0 && row_of(q[m_ch][0]) == lr && m_streak < MS) begin
        exp_pop[m_ch] = 1'b1;
        m_adrs = q[m_ch].pop_front();
        m_streak++;
        m_hit = 1'b1;
      end else begin
        g = rr_pick();
        if (g >= 0) begin
          exp_pop[g] = 1'b1;
          m_adrs = q[g].pop_front();
          m_hit = (row_of(m_adrs) == lr);
          m_ch = g; m_last_grant = g; m_streak = 1;
        end else begin
          m_valid = 1'b0; m_hit = 1'b0; m_lrv = 1'b0;
        end
      end
    end
    chk("ch_pop", 64'(ch_pop), 64'(exp_pop));
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b1);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    ready = 1'b0;
    ch_empty = '1;
    ch_adrs = '0;
    model_reset();
    @(negedge clk);

    // Reset held with every queue non-empty, then channel 0 goes first.
    q[0].push_back(32'h0000_0100);
    q[1].push_back(32'h0000_0200);
    q[2].push_back(32'h0000_0300);
    do_reset(3);
    expect_cmd(0, 1'b0, 32'h0000_0100);
    expect_cmd(1, 1'b1, 32'h0000_0200);
    expect_cmd(2, 1'b1, 32'h0000_0300);
    run(6);

    // Single request.
    do_reset(2);
    q[0].push_back(32'h0000_2000);
    expect_cmd(0, 1'b0, 32'h0000_2000);
    run(4);

    // Round-robin alternation, no row hits.
    do_reset(2);
    q[0].push_back(32'h0000_2000); q[0].push_back(32'h0000_6000);
    q[1].push_back(32'h0001_0000); q[1].push_back(32'h0001_4000);
    expect_cmd(0, 1'b0, 32'h0000_2000);
    expect_cmd(1, 1'b0, 32'h0001_0000);
    expect_cmd(0, 1'b0, 32'h0000_6000);
    expect_cmd(1, 1'b0, 32'h0001_4000);
    run(7);

    // Row-hit streak capped at MAX_STREAK, then forced rotation.
    do_reset(2);
    for (int k = 0; k < 6; k++) q[0].push_back(32'h0000_4000 + 32'(k * 'h40));
    q[1].push_back(32'h0008_0000);
    expect_cmd(0, 1'b0, 32'h0000_4000);
    expect_cmd(0, 1'b1, 32'h0000_4040);
    expect_cmd(0, 1'b1, 32'h0000_4080);
    expect_cmd(0, 1'b1, 32'h0000_40C0);
    expect_cmd(1, 1'b0, 32'h0008_0000);
    expect_cmd(0, 1'b0, 32'h0000_4100);
    expect_cmd(0, 1'b1, 32'h0000_4140);
    run(10);
`ifdef DDR_ARB_STATS_EN
    chk("stats_issue_7", 64'(issue_cnt), 64'd7);
    chk("stats_hit_4", 64'(hit_cnt), 64'd4);
`endif

    // Backpressure: three stalled cycles with ch1 waiting, then transfer.
    do_reset(2);
    q[0].push_back(32'h0000_2000);
    q[1].push_back(32'h0001_0000);
    expect_cmd(0, 1'b0, 32'h0000_2000);
    expect_cmd(1, 1'b0, 32'h0001_0000);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    run(4);

    // Random traffic with row locality, random ready and occasional reset.
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (q[c].size() < 6 && $urandom_range(0, 99) < 30) begin
          if ($urandom_range(0, 9) == 0)
            q[c].push_back(AW'($urandom()));
          else
            q[c].push_back((AW'($urandom_range(0, 3)) << RL) | AW'($urandom_range(0, (1 << RL) - 1)));
        end
      end
      step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
